// File: rtl/clk_divider_multi.sv
// clk_divider_multi: CH independent integer clock dividers with glitch-free divisor reload at period boundaries.
// Optional macro CLK_DIVIDER_MULTI_HALF_DUTY_EN stretches the high phase by half a cycle for odd divisors.
module clk_divider_multi #(
   parameter int unsigned     CH      = 4,
   parameter int unsigned     CNT_W   = 32,
   parameter longint unsigned DEF_DIV = 64'd100000000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CH-1:0]       en,
   input  logic [CH*CNT_W-1:0] div_val,
   input  logic [CH-1:0]       div_load,
   output logic [CH-1:0]       d_clk,
   output logic [CH-1:0]       tick,
   output logic [CH-1:0]       busy
);

   // Divisors below 2 cannot form a high and a low phase, so they run as 2.
   localparam logic [CNT_W-1:0] DEF_N = (DEF_DIV < 64'd2) ? CNT_W'(2) : CNT_W'(DEF_DIV);

   function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] v);
      return (v < CNT_W'(2)) ? CNT_W'(2) : v;
   endfunction

   for (genvar i = 0; i < CH; i++) begin : g_ch
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [CNT_W-1:0] div_q, div_d;
      logic [CNT_W-1:0] pend_q, pend_d;
      logic [CNT_W-1:0] cnt_inc;
      logic             run_q, run_d;
      logic             dclk_q, dclk_d;
      logic             tick_q, tick_d;
      logic             busy_q, busy_d;
      logic             apply;

      assign cnt_inc = cnt_q + CNT_W'(1);

      always_comb begin
         // NOTE: every variable gets a default first so no latch is inferred.
         cnt_d  = cnt_q;
         run_d  = run_q;
         dclk_d = dclk_q;
         tick_d = 1'b0;
         div_d  = div_q;
         pend_d = pend_q;
         busy_d = busy_q;
         apply  = 1'b0;

         if (!en[i]) begin
            run_d  = 1'b0;
            cnt_d  = '0;
            dclk_d = 1'b0;
            apply  = busy_q;
         end else if (!run_q) begin
            run_d  = 1'b1;
            cnt_d  = '0;
            dclk_d = 1'b1;
            tick_d = 1'b1;
            apply  = busy_q;
         end else if (cnt_q == div_q - CNT_W'(1)) begin
            cnt_d  = '0;
            dclk_d = 1'b1;
            tick_d = 1'b1;
            apply  = busy_q;
         end else begin
            cnt_d  = cnt_inc;
            dclk_d = (cnt_inc < (div_q >> 1));
         end

         // Only the previously stored value is applied; a load on this edge waits for the next boundary.
         if (apply) begin
            div_d  = clamp_div(pend_q);
            busy_d = 1'b0;
         end
         if (div_load[i]) begin
            pend_d = div_val[i*CNT_W +: CNT_W];
            busy_d = 1'b1;
         end
      end

      // NOTE: sequential state uses non-blocking assignments only; the pending register is reset like all other state.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q  <= '0;
            run_q  <= 1'b0;
            dclk_q <= 1'b0;
            tick_q <= 1'b0;
            busy_q <= 1'b0;
            div_q  <= DEF_N;
            pend_q <= '0;
         end else begin
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            dclk_q <= dclk_d;
            tick_q <= tick_d;
            busy_q <= busy_d;
            div_q  <= div_d;
            pend_q <= pend_d;
         end
      end

`ifdef CLK_DIVIDER_MULTI_HALF_DUTY_EN
      logic neg_q;

      // Half-cycle copy of the phase; ORed in only for odd divisors to give exactly N/2 high.
      always_ff @(negedge clk or negedge rst_n) begin
         if (!rst_n) begin
            neg_q <= 1'b0;
         end else if (!en[i]) begin
            neg_q <= 1'b0;
         end else begin
            neg_q <= dclk_q;
         end
      end

      assign d_clk[i] = dclk_q | (neg_q & div_q[0]);
`else
      assign d_clk[i] = dclk_q;
`endif
      assign tick[i] = tick_q;
      assign busy[i] = busy_q;
   end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Testbench for clk_divider_multi: directed test-plan steps plus random loads/enables against a
// period-timestamp reference model.
module tb_clk_divider_multi;
   localparam int              CH      = 4;
   localparam int              CNT_W   = 32;
   localparam longint unsigned DEF_DIV = 64'd100000000;
`ifdef CLK_DIVIDER_MULTI_HALF_DUTY_EN
   localparam bit HALF = 1'b1;
`else
   localparam bit HALF = 1'b0;
`endif

   logic                clk      = 1'b0;
   logic                rst_n    = 1'b0;
   logic [CH-1:0]       en       = '0;
   logic [CH*CNT_W-1:0] div_val  = '0;
   logic [CH-1:0]       div_load = '0;
   logic [CH-1:0]       d_clk;
   logic [CH-1:0]       tick;
   logic [CH-1:0]       busy;

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;

   // Reference model: each channel remembers the clk count at which its current period began.
   longint cyc;
   longint m_n[CH];
   longint m_pend[CH];
   longint m_start[CH];
   bit     m_run[CH];
   bit     m_busy[CH];
   bit     m_phase[CH];
   bit     m_prev[CH];
   bit     m_tick[CH];

   always #5 clk = ~clk;

   clk_divider_multi #(
      .CH     (CH),
      .CNT_W  (CNT_W),
      .DEF_DIV(DEF_DIV)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .div_val (div_val),
      .div_load(div_load),
      .d_clk   (d_clk),
      .tick    (tick),
      .busy    (busy)
   );

   task automatic check(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   function automatic longint clampv(input longint v);
      return (v < 2) ? 64'd2 : v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < CH; i++) begin
         m_n[i]     = longint'(DEF_DIV);
         m_pend[i]  = 0;
         m_start[i] = 0;
         m_run[i]   = 1'b0;
         m_busy[i]  = 1'b0;
         m_phase[i] = 1'b0;
         m_prev[i]  = 1'b0;
         m_tick[i]  = 1'b0;
      end
   endtask

   task automatic model_edge();
      cyc++;
      for (int i = 0; i < CH; i++) begin
         bit     boundary;
         longint pos;
         boundary  = 1'b0;
         m_prev[i] = m_phase[i];
         pos       = cyc - m_start[i];
         if (!en[i]) begin
            m_run[i]   = 1'b0;
            m_phase[i] = 1'b0;
            m_tick[i]  = 1'b0;
            boundary   = 1'b1;
         end else if (!m_run[i] || pos == m_n[i]) begin
            m_run[i]   = 1'b1;
            m_start[i] = cyc;
            m_phase[i] = 1'b1;
            m_tick[i]  = 1'b1;
            boundary   = 1'b1;
         end else begin
            m_tick[i]  = 1'b0;
            m_phase[i] = (pos < m_n[i] / 2);
         end
         if (boundary && m_busy[i]) begin
            m_n[i]    = clampv(m_pend[i]);
            m_busy[i] = 1'b0;
         end
         if (div_load[i]) begin
            m_pend[i] = longint'(div_val[i*CNT_W +: CNT_W]);
            m_busy[i] = 1'b1;
         end
      end
   endtask

   task automatic check_all(input string what);
      for (int i = 0; i < CH; i++) begin
         logic exp_d;
         exp_d = m_phase[i] | (HALF & en[i] & m_n[i][0] & m_prev[i]);
         check($sformatf("%s tick[%0d] cyc %0d", what, i, cyc), tick[i], m_tick[i]);
         check($sformatf("%s d_clk[%0d] cyc %0d", what, i, cyc), d_clk[i], exp_d);
         check($sformatf("%s busy[%0d] cyc %0d", what, i, cyc), busy[i], m_busy[i]);
      end
   endtask

   task automatic step(input string what);
      @(posedge clk);
      model_edge();
      #1;
      check_all(what);
      div_load = '0;
   endtask

   task automatic steps(input string what, input int n);
      for (int k = 0; k < n; k++) step(what);
   endtask

   task automatic load(input int ch, input longint unsigned v);
      div_val[ch*CNT_W +: CNT_W] = v[CNT_W-1:0];
      div_load[ch]               = 1'b1;
   endtask

   initial begin
      cyc = 0;
      model_reset();
      #12;
      check_all("reset");
      rst_n = 1'b1;

      // Plan 1: N=4 on ch0.
      load(0, 4);
      step("load4");
      en[0] = 1'b1;
      steps("n4", 10);

      // Plan 2: N=5 on ch1.
      load(1, 5);
      step("load5");
      en[1] = 1'b1;
      steps("n5", 12);

      // Plan 3: reload ch0 with 6 early in a period.
      for (int k = 0; k < 8 && !m_tick[0]; k++) step("align");
      load(0, 6);
      steps("n4to6", 18);

      // Plan 4: 0 then 1 on ch2 run as 2; then 3.
      load(2, 0);
      step("load0");
      load(2, 1);
      step("load1");
      en[2] = 1'b1;
      steps("n2", 6);
      load(2, 3);
      steps("n3", 9);

      // Plan 5: asynchronous reset during ch0 high phase, en held high.
      load(3, 7);
      en = '1;
      for (int k = 0; k < 8 && !m_tick[0]; k++) step("pre_rst");
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      #1;
      rst_n = 1'b1;
      steps("def_div", 5);

      // Plan 6: 2,3,4,7 loaded together, enabled together, then ch2 dropped.
      en = '0;
      load(0, 2);
      load(1, 3);
      load(2, 4);
      load(3, 7);
      step("load_all");
      step("apply_all");
      en = '1;
      steps("all", 20);
      en[2] = 1'b0;
      steps("ch2_off", 12);

      // Load and enable drop on the same edge, then load on a first-enable edge.
      load(1, 4);
      en[1] = 1'b0;
      step("load_en_fall");
      en[1] = 1'b1;
      step("apply_off");
      load(1, 5);
      en[2] = 1'b1;
      load(2, 2);
      steps("load_first", 12);

      // Largest divisor is legal.
      load(3, 64'hFFFF_FFFF);
      en[3] = 1'b0;
      step("max_load");
      en[3] = 1'b1;
      steps("max_run", 6);

      // Random loads and enables.
      for (int k = 0; k < 300; k++) begin
         for (int i = 0; i < CH; i++) begin
            if ($urandom_range(0, 7) == 0) load(i, longint'($urandom_range(0, 9)));
            if ($urandom_range(0, 15) == 0) en[i] = ~en[i];
         end
         step("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/clk_divider_multi.md
Name: clk_divider_multi

Overview:
Parametrised multi-channel clock divider for the 100 MHz board clock. It replaces the single-channel, fixed-compare divider. Each channel has:
- a runtime-loadable integer divisor N;
- an enable;
- a divided clock output with defined duty;
- a one-cycle period-start tick for use as a clock enable.

Divisor changes are glitch-free: they take effect only at a period boundary.

Parameters:
CH, 4, number of independent divider channels (1..16)
CNT_W, 32, width of each divisor and each period counter
DEF_DIV, 100000000, divisor loaded into every channel at reset (1 Hz from 100 MHz)

Ports:
clk  input  1  system clock, all logic on posedge (negedge only under the optional feature)
rst_n  input  1  asynchronous active-low reset
en  input  CH  per-channel run enable, synchronous, level
div_val  input  CH*CNT_W  packed divisors; channel i uses bits [i*CNT_W +: CNT_W]
div_load  input  CH  per-channel one-cycle strobe that captures the div_val slice
d_clk  output  CH  divided clock per channel, registered
tick  output  CH  one-cycle pulse at the start of each period, registered
busy  output  CH  high while a loaded divisor is pending and not yet applied

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-period):
  - all cnt = 0, running = 0, d_clk = 0, tick = 0, busy = 0;
  - active divisor = DEF_DIV; pending register cleared.
- Divisor clamp: the effective N = max(divisor, 2). Values 0 and 1 behave as 2. The clamp is applied when the divisor becomes active.
- High-phase length H = floor(N/2). Low phase = N - H.
- Load:
  - div_load[i] high on an edge stores the div_val slice in pend[i] and sets busy[i] = 1 on that edge.
  - A second load before application overwrites pend; the last write wins.
- Per channel, each posedge, checked in priority order:
  1. en[i] = 0: running <= 0, cnt <= 0, d_clk <= 0, tick <= 0. The pending divisor is applied immediately (busy <= 0).
  2. en[i] = 1 and running = 0 (first enabled edge): running <= 1, cnt <= 0, d_clk <= 1, tick <= 1. A pending divisor is applied on this edge.
  3. en[i] = 1, running = 1, cnt == N-1 (wrap): cnt <= 0, tick <= 1, d_clk <= 1. A pending divisor is applied here (busy <= 0) and governs the new period.
  4. Otherwise: cnt <= cnt+1, tick <= 0, d_clk <= (cnt+1 < H).
- Resulting waveform: the tick rising edge coincides with the d_clk rising edge. Periods are exactly N clk cycles, with H cycles high and N-H cycles low.
- Latency: the first tick and the first d_clk rise occur on the first edge with en = 1.
- Simultaneous events:
  - div_load on the same edge as a wrap or first-enable: the new value is NOT applied on that edge. It is stored and applied at the next boundary.
  - en falling on the same edge as div_load: the load is stored and applied on the next edge, since the channel is disabled then.
- Channels are fully independent; no cross-channel phase relationship is guaranteed.
- Counter never exceeds N-1. A divisor at 2^CNT_W-1 is legal.

Optional Feature:
Macro CLK_DIVIDER_MULTI_HALF_DUTY_EN.
- Defined, odd N:
  - d_clk is the OR of the posedge-registered phase and a copy of that phase re-registered on negedge clk;
  - the high time is N/2 clk periods exactly (e.g. 1.5 for N = 3). Even N is unchanged.
  - the negedge flop is reset by rst_n and cleared when en[i] = 0.
- Not defined: no negedge logic, and the high time is H = floor(N/2) cycles.
- tick is identical in both builds.

Test Plan:
1. Reset then en[0] = 1 with N = 4 loaded → tick[0] every 4 cycles starting on the first enabled edge; d_clk[0] pattern 1,1,0,0 repeating; busy[0] cleared by the first edge.
2. N = 5 on ch1 without the macro → d_clk[1] pattern 1,1,0,0,0, period 5. With the macro defined, high time = 2.5 cycles, measured to the negedge.
3. Running at N = 4, div_load with 6 at cnt = 1 → busy = 1 until the next wrap; the current period still lasts 4 cycles, then periods of 6 with 3 high; tick spacing 4 then 6.
4. Load 0 and then 1 on ch2 → behaves as N = 2 (d_clk toggles every cycle, tick every 2 cycles); load 3 → pattern 1,0,0.
5. Assert rst_n low asynchronously mid-high-phase on all channels → d_clk, tick and busy drop to 0 without waiting for a clk edge. After release with en held high, the first edge gives tick = 1 at DEF_DIV.
6. CH = 4 with divisors 2, 3, 4, 7 loaded simultaneously and enabled together → every channel ticks on the first edge, then independently at its own period. Dropping en[2] does not disturb the other channels.
